// File: rtl/sha256_block_assembler_if.sv
// ---------------------------------------------------------------------------
// sha256_block_assembler_if
// Stream bundle around the SHA-256 block assembler.
//   in_*  : 64-bit read-data beats from the memory engine (valid/ready)
//   blk_* : 512-bit message blocks towards the hash core (valid/ready)
// Modports:
//   master : the assembler side (accepts beats, produces blocks)
//   slave  : the environment side (memory engine + hash core)
// ---------------------------------------------------------------------------
interface sha256_block_assembler_if;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_last;

    modport master (
        input  in_valid, in_data, blk_ready,
        output in_ready, blk_valid, blk_data, blk_last
    );

    modport slave (
        output in_valid, in_data, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_last
    );
endinterface

// File: rtl/sha256_block_assembler.sv
// ---------------------------------------------------------------------------
// sha256_block_assembler
// Packs 64-bit little-address-first read beats into 512-bit SHA-256 message
// blocks (big-endian byte order), then appends 0x80, zero fill and the 64-bit
// message bit-length. Blocks leave one at a time over a valid/ready port.
// Ports:
//   i_clk     clock
//   i_reset   synchronous reset, active-high
//   i_go      single-cycle start pulse (honoured only when idle)
//   i_length  message length in bytes, must be a multiple of 8
//   o_busy    high while a message is in progress
//   o_done    one-cycle pulse after the final block handshake
//   o_err     sticky misaligned-length flag, cleared by the next accepted go
//   bus       beat input / block output streams (master modport)
// ---------------------------------------------------------------------------
module sha256_block_assembler #(
    parameter int IN_WIDTH  = 64,
    parameter int BLK_WIDTH = 512
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_go,
    input  logic [31:0] i_length,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    sha256_block_assembler_if.master bus
);

    localparam int BEATS = BLK_WIDTH / IN_WIDTH;   // beat slots per block
    localparam int BYTES = IN_WIDTH / 8;           // bytes per beat

    typedef enum logic [2:0] {
        S_IDLE,
        S_MSG,
        S_PAD,
        S_ZERO,
        S_LEN,
        S_OUT
    } state_t;

    state_t                 r_state, w_state_next;
    state_t                 r_pend,  w_pend_next;   // where to resume after OUT
    logic [31:0]            r_len;                  // message length in bytes
    logic [28:0]            r_n;                    // message beats still to come
    logic [2:0]             r_p;                    // next beat slot in the block
    logic [BLK_WIDTH-1:0]   r_buf;
    logic                   r_last;
    logic                   r_err;
    logic                   r_done;

    logic                   w_go_ok;
    logic                   w_beat_acc;
    logic                   w_blk_hs;
    logic                   w_p_last;
    logic                   w_p_six;
    logic                   w_n_last;
    logic                   w_wr;
    logic [IN_WIDTH-1:0]    w_wr_data;
    logic [IN_WIDTH-1:0]    w_beat_be;

    assign w_go_ok    = i_go && (i_length[2:0] == 3'd0);
    assign w_beat_acc = (r_state == S_MSG) && bus.in_valid;
    assign w_blk_hs   = (r_state == S_OUT) && bus.blk_ready;
    assign w_p_last   = (r_p == 3'(BEATS - 1));
    assign w_p_six    = (r_p == 3'(BEATS - 2));
    assign w_n_last   = (r_n == 29'd1);

    // Byte 0 of the beat is the lowest address, so it lands in the most
    // significant byte of the slot (SHA-256 words are big-endian).
    always_comb begin
        w_beat_be = '0;
        for (int j = 0; j < BYTES; j++) begin
            w_beat_be[IN_WIDTH-1-8*j -: 8] = bus.in_data[8*j +: 8];
        end
    end

    // ---------------------------------------------------------------- FSM
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_pend_next  = r_pend;
        w_wr         = 1'b0;
        w_wr_data    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_go_ok) begin
                    w_state_next = (i_length == 32'd0) ? S_PAD : S_MSG;
                end
            end
            S_MSG: begin
                if (w_beat_acc) begin
                    w_wr      = 1'b1;
                    w_wr_data = w_beat_be;
                    if (w_p_last) begin
                        w_state_next = S_OUT;
                        w_pend_next  = w_n_last ? S_PAD : S_MSG;
                    end else if (w_n_last) begin
                        w_state_next = S_PAD;
                    end
                end
            end
            S_PAD: begin
                w_wr      = 1'b1;
                w_wr_data = {8'h80, {(IN_WIDTH-8){1'b0}}};
                if (w_p_last) begin
                    // No room for the length: flush and start a zero block.
                    w_state_next = S_OUT;
                    w_pend_next  = S_ZERO;
                end else if (w_p_six) begin
                    w_state_next = S_LEN;
                end else begin
                    w_state_next = S_ZERO;
                end
            end
            S_ZERO: begin
                w_wr      = 1'b1;
                w_wr_data = '0;
                if (w_p_six) begin
                    w_state_next = S_LEN;
                end
            end
            S_LEN: begin
                w_wr      = 1'b1;
                w_wr_data = {29'd0, r_len, 3'd0};
                w_state_next = S_OUT;
            end
            S_OUT: begin
                if (w_blk_hs) begin
                    w_state_next = r_last ? S_IDLE : r_pend;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_pend  <= S_MSG;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
        end
    end

    // ----------------------------------------------------------- datapath
    // NOTE: the block buffer is reset because blk_data must read zero out of
    // reset and an aborted partial block must not leak into the next message.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_buf  <= '0;
            r_p    <= '0;
            r_n    <= '0;
            r_len  <= '0;
            r_last <= 1'b0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_go) begin
                        if (w_go_ok) begin
                            r_len <= i_length;
                            r_n   <= i_length[31:3];
                            r_p   <= '0;
                            r_err <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (w_blk_hs) begin
                        r_p   <= '0;
                        r_buf <= '0;
                        if (r_last) begin
                            r_done <= 1'b1;
                            r_last <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (w_wr) begin
                        r_buf[(BEATS-1-int'(r_p))*IN_WIDTH +: IN_WIDTH] <= w_wr_data;
                        r_p <= r_p + 3'd1;
                        if (r_state == S_MSG) begin
                            r_n <= r_n - 29'd1;
                        end
                        if (r_state == S_LEN) begin
                            r_last <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------ outputs
    assign bus.in_ready  = (r_state == S_MSG);
    assign bus.blk_valid = (r_state == S_OUT);
    assign bus.blk_data  = r_buf;
    assign bus.blk_last  = r_last;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = r_done;
    assign o_err         = r_err;

endmodule

// File: tb/tb_sha256_block_assembler.sv
// ---------------------------------------------------------------------------
// tb_sha256_block_assembler
// Directed bench for sha256_block_assembler: zero-length message, 80-byte
// header, 56-byte boundary, 64-byte message under backpressure, misaligned
// length error, and reset abort. Expected blocks are hand-built constants.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sha256_block_assembler;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic [31:0] length;
    logic        busy;
    logic        done;
    logic        err;

    sha256_block_assembler_if bus ();

    sha256_block_assembler dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_go     (go),
        .i_length (length),
        .o_busy   (busy),
        .o_done   (done),
        .o_err    (err),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Expected blocks (block byte k at bits [511-8k -: 8]).
    localparam logic [511:0] B_L0   = {8'h80, 504'h0};
    localparam logic [511:0] B_SEQ  = 512'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f;
    localparam logic [511:0] B80_1  = {128'h404142434445464748494a4b4c4d4e4f, 8'h80, 312'h0, 64'h0000000000000280};
    localparam logic [511:0] B56_0  = {448'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f202122232425262728292a2b2c2d2e2f3031323334353637, 8'h80, 56'h0};
    localparam logic [511:0] B56_1  = {448'h0, 64'h00000000000001c0};
    localparam logic [511:0] B64_1  = {8'h80, 440'h0, 64'h0000000000000200};
    localparam logic [511:0] B8     = {64'h0001020304050607, 8'h80, 376'h0, 64'h0000000000000040};

    // ------------------------------------------------------------ stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_go(input logic [31:0] len);
        go     = 1'b1;
        length = len;
        tick();
        go     = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d);
        int cyc;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        cyc = 0;
        while (bus.in_ready !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        if (cyc >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_timeout: in_ready=%b after 100 cycles, required 1", bus.in_ready);
        end else begin
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    // Beat i of the test pattern carries bytes 8i..8i+7 in address order.
    task automatic send_beats(input int first, input int count);
        for (int i = 0; i < count; i++) begin
            send_beat(64'h0706050403020100 + 64'(first + i) * 64'h0808080808080808);
        end
    endtask

    // Waits for a block, optionally holds blk_ready low for 'hold' cycles while
    // offering a stray beat, then completes the handshake. 'bad' counts hold
    // cycles where blk_valid dropped, blk_data changed or in_ready rose.
    task automatic get_block(input int hold, output logic [511:0] d,
                             output logic l, output int bad);
        int cyc;
        bad = 0;
        cyc = 0;
        d   = 'x;
        l   = 1'bx;
        while (bus.blk_valid !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        if (cyc >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL block_timeout: blk_valid=%b after 200 cycles, required 1", bus.blk_valid);
        end else begin
            d = bus.blk_data;
            l = bus.blk_last;
            bus.in_valid = 1'b1;
            bus.in_data  = 64'hdeadbeefdeadbeef;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (bus.blk_valid !== 1'b1 || bus.blk_data !== d || bus.in_ready !== 1'b0) bad++;
            end
            bus.in_valid  = 1'b0;
            bus.blk_ready = 1'b1;
            tick();
            bus.blk_ready = 1'b0;
        end
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        reset        = 1'b1;
        go           = 1'b1;        // must be ignored while reset is high
        length       = 32'd0;
        bus.in_valid = 1'b1;
        tick();
        tick();
        reset        = 1'b0;
        go           = 1'b0;
        bus.in_valid = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        n_tests++; if (bus.blk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_blk_valid: got %b want 0", bus.blk_valid); end
        n_tests++; if (bus.blk_last !== 1'b0) begin n_fail++; $display("FAIL reset_blk_last: got %b want 0", bus.blk_last); end
        n_tests++; if (bus.blk_data !== 512'h0) begin n_fail++; $display("FAIL reset_blk_data: got %h want 0", bus.blk_data); end
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_go_ignored: busy got %b want 0", busy); end
    endtask

    task automatic test_zero_length();
        logic [511:0] d;
        logic         l;
        int           bad;
        pulse_go(32'd0);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL l0_busy_rise: got %b want 1", busy); end
        get_block(0, d, l, bad);
        n_tests++; if (d !== B_L0) begin n_fail++; $display("FAIL l0_block: got %h want %h", d, B_L0); end
        n_tests++; if (l !== 1'b1) begin n_fail++; $display("FAIL l0_last: got %b want 1", l); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL l0_done: got %b want 1", done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL l0_busy_fall: got %b want 0", busy); end
        tick();
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL l0_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_header80();
        logic [511:0] d;
        logic         l;
        int           bad;
        pulse_go(32'd80);
        send_beats(0, 8);
        n_tests++; if (bus.blk_valid !== 1'b1) begin n_fail++; $display("FAIL h80_valid_latency: got %b want 1", bus.blk_valid); end
        get_block(0, d, l, bad);
        n_tests++; if (d !== B_SEQ) begin n_fail++; $display("FAIL h80_block0: got %h want %h", d, B_SEQ); end
        n_tests++; if (l !== 1'b0) begin n_fail++; $display("FAIL h80_last0: got %b want 0", l); end
        send_beats(8, 2);
        get_block(0, d, l, bad);
        n_tests++; if (d !== B80_1) begin n_fail++; $display("FAIL h80_block1: got %h want %h", d, B80_1); end
        n_tests++; if (l !== 1'b1) begin n_fail++; $display("FAIL h80_last1: got %b want 1", l); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL h80_done: got %b want 1", done); end
        tick();
    endtask

    task automatic test_len56();
        logic [511:0] d;
        logic         l;
        int           bad;
        pulse_go(32'd56);
        send_beats(0, 7);
        get_block(0, d, l, bad);
        n_tests++; if (d !== B56_0) begin n_fail++; $display("FAIL l56_block0: got %h want %h", d, B56_0); end
        n_tests++; if (l !== 1'b0) begin n_fail++; $display("FAIL l56_last0: got %b want 0", l); end
        get_block(0, d, l, bad);
        n_tests++; if (d !== B56_1) begin n_fail++; $display("FAIL l56_block1: got %h want %h", d, B56_1); end
        n_tests++; if (l !== 1'b1) begin n_fail++; $display("FAIL l56_last1: got %b want 1", l); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [511:0] d;
        logic         l;
        int           bad;
        int           cnt0;
        cnt0 = done_cnt;
        pulse_go(32'd64);
        send_beats(0, 8);
        n_tests++; if (bus.blk_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_latency: got %b want 1", bus.blk_valid); end
        get_block(20, d, l, bad);
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold0: %0d unstable cycles, want 0", bad); end
        n_tests++; if (d !== B_SEQ) begin n_fail++; $display("FAIL bp_block0: got %h want %h", d, B_SEQ); end
        n_tests++; if (l !== 1'b0) begin n_fail++; $display("FAIL bp_last0: got %b want 0", l); end
        get_block(20, d, l, bad);
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold1: %0d unstable cycles, want 0", bad); end
        n_tests++; if (d !== B64_1) begin n_fail++; $display("FAIL bp_block1: got %h want %h", d, B64_1); end
        n_tests++; if (l !== 1'b1) begin n_fail++; $display("FAIL bp_last1: got %b want 1", l); end
        repeat (4) tick();
        n_tests++; if (done_cnt - cnt0 !== 1) begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", done_cnt - cnt0); end
    endtask

    task automatic test_err();
        logic [511:0] d;
        logic         l;
        int           bad;
        pulse_go(32'd12);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL err_busy: got %b want 0", busy); end
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL err_in_ready: got %b want 0", bus.in_ready); end
        repeat (3) tick();
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
        pulse_go(32'd8);
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL err_restart_busy: got %b want 1", busy); end
        pulse_go(32'd12);           // mid-message, must be ignored
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_mid_go: got %b want 0", err); end
        send_beats(0, 1);
        get_block(0, d, l, bad);
        n_tests++; if (d !== B8) begin n_fail++; $display("FAIL err_l8_block: got %h want %h", d, B8); end
        n_tests++; if (l !== 1'b1) begin n_fail++; $display("FAIL err_l8_last: got %b want 1", l); end
        tick();
    endtask

    task automatic test_reset_abort();
        logic [511:0] d;
        logic         l;
        int           bad;
        int           cnt0;
        cnt0 = done_cnt;
        pulse_go(32'd64);
        send_beats(0, 3);
        reset        = 1'b1;
        bus.in_valid = 1'b1;        // beat coincident with reset is dropped
        bus.in_data  = 64'h1f1e1d1c1b1a1918;
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        n_tests++; if (bus.blk_valid !== 1'b0) begin n_fail++; $display("FAIL abort_blk_valid: got %b want 0", bus.blk_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_in_ready: got %b want 0", bus.in_ready); end
        repeat (10) tick();
        n_tests++; if (done_cnt !== cnt0) begin n_fail++; $display("FAIL abort_no_done: got %0d dones want 0", done_cnt - cnt0); end
        pulse_go(32'd0);
        get_block(0, d, l, bad);
        n_tests++; if (d !== B_L0) begin n_fail++; $display("FAIL abort_l0_block: got %h want %h", d, B_L0); end
        n_tests++; if (l !== 1'b1) begin n_fail++; $display("FAIL abort_l0_last: got %b want 1", l); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL abort_l0_done: got %b want 1", done); end
        tick();
    endtask

    initial begin
        reset         = 1'b0;
        go            = 1'b0;
        length        = 32'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 64'h0;
        bus.blk_ready = 1'b0;
        tick();
        test_reset();
        test_zero_length();
        test_header80();
        test_len56();
        test_backpressure();
        test_err();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded 1 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sha256_block_assembler.md
# sha256_block_assembler

Sits directly downstream of the single-read AXI4 memory engine in the miner SoC. Consumes the 64-bit read-data beats fetched from DRAM and packs them into 512-bit SHA-256 message blocks in big-endian word order. After the last message beat it appends standard SHA-256 padding and the 64-bit message bit-length. Complete blocks are handed one at a time over a valid/ready port to the hash core.

## Interface
Parameters:
- IN_WIDTH, 64, input beat width in bits; fixed, only 64 supported
- BLK_WIDTH, 512, output block width in bits; fixed

Ports:
- Clk  in  1  clock
- RESET  in  1  synchronous reset, active-high
- Go  in  1  single-cycle start pulse, driven by the auto-cleared control_go register bit
- length  in  32  message length in bytes; must be a multiple of 8
- Busy  out  1  high while a message is in progress
- Done  out  1  one-cycle pulse after the final block handshake
- Err  out  1  sticky; set when Go arrives with length[2:0] != 0; cleared by the next accepted Go or by RESET
- in_valid  in  1  read-data beat valid (AXI R channel rvalid)
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  64  beat; byte 0 (bits 7:0) is the lowest-address byte
- blk_valid  out  1  block valid
- blk_ready  in  1  block consumed when blk_valid && blk_ready
- blk_data  out  512  block; block byte k is at bits [511-8k -: 8]
- blk_last  out  1  qualifies blk_data as the final block of the message

## Operation
- States: IDLE, MSG, PAD, ZERO, LEN, OUT.
- IDLE: Go && length[2:0]==0 latches L=length, sets beat counter N=L/8, clears the beat index p, clears Err, and moves to MSG (or to PAD if L==0). Go with a misaligned length sets Err and stays in IDLE.
- Go is ignored in every state other than IDLE.
- MSG: in_ready=1. Each accepted beat writes its 8 bytes, in address order, into block bytes 8p..8p+7. Then p increments and N decrements.
- Leaving MSG: when a beat fills p==7, go to OUT and return to MSG afterwards. When N reaches 0, go to PAD, via OUT first if that beat filled the block.
- PAD: writes beat {0x80, 7×0x00} at position p.
  - If p<=6 after the write, go to ZERO (or to LEN if p is now 7).
  - If the PAD beat occupied position 7, go to OUT, then ZERO for the next block.
- ZERO: writes zero beats, one per cycle, until p==7, then goes to LEN.
- LEN: writes the 64-bit big-endian value {29'b0, L, 3'b0} at bytes 56..63, then goes to OUT with blk_last=1.
- OUT: blk_valid=1; blk_data and blk_last are stable until blk_ready. On handshake, p clears and the block buffer clears. Then:
  - if blk_last, pulse Done and go to IDLE;
  - otherwise return to the pending state.
- in_ready=0 in every state except MSG. Beats offered outside MSG are not consumed.
- Extra beats beyond L/8 are the upstream engine's responsibility; this block never requests them.
- Busy=1 in all states except IDLE.

## Timing
- Reset values:
  - Busy=0, Done=0, Err=0
  - in_ready=0, blk_valid=0, blk_last=0
  - blk_data=0, state=IDLE
- Busy rises the cycle after Go is sampled.
- The 8th beat of a block is accepted in cycle t; blk_valid=1 at t+1.
- PAD, ZERO and LEN each take one cycle per beat and need no input.
- Block throughput is at most one per 9 cycles (8 fill cycles plus ≥1 OUT cycle). There is no overlap of fill and output.
- Done is high for exactly one cycle, the cycle after the final blk handshake. Busy falls in that same cycle.
- Backpressure: blk_valid, once raised, stays high with unchanged blk_data until blk_ready.
- RESET in any state aborts the message next edge: the partial block is discarded, blk_valid drops, and no Done is issued.
- in_valid and Go in the same cycle as RESET are ignored.
- Bit-length arithmetic is 64-bit zero-extended. The maximum L is 2^32−8 bytes.

## Test plan
- L=0: Go, no input beats → one block 0x80000000_00…_00000000_00000000, blk_last=1, Done one cycle after handshake.
- L=80 (bitcoin header, 10 beats 0x0706050403020100+i·0x0808080808080808) → block 0 = bytes 00..3F big-endian-ordered; block 1 = bytes 40..4F, 0x80, zeros, last 64 bits 0x0000000000000280, blk_last=1.
- L=56 (7 beats) → block 0 has 0x80 at byte 56 followed by zeros, blk_last=0; block 1 is all zero except the last 64 bits = 0x1C0, blk_last=1.
- L=64 with blk_ready held low 20 cycles on each block → in_ready=0 throughout OUT, blk_data stable; second block = 0x80…, length 0x200; exactly one Done.
- Go with length=12 → Err=1, Busy stays 0, in_ready stays 0. A subsequent Go with length=8 clears Err and runs normally. A Go pulsed mid-message is ignored.
- RESET asserted after 3 beats of L=64 → next cycle blk_valid=0, Busy=0, no Done. A new Go with L=0 then produces the correct single block.
